cdc_handshake_tx: RTL
=====================

Name: cdc_handshake_tx

Overview:
- Source-side (sending) end of a 4-phase req/ack clock-domain crossing.
- Accepts a word over a local valid/ready interface and drives a stable data bus plus a level `req` toward a foreign clock domain.
- The receiver's asynchronous `ack` is brought into the `clk` domain through an internal flop chain. Complements the receive-side synchronizer already in the design.
- Sits between a local producer and an unrelated-clock consumer.

Parameters:
- WIDTH, 8, width of the transferred data word.
- SYNC_STAGES, 3, flops in the `ack` synchronizer chain; legal range ≥ 2.

Ports:
- clk  input  1  sole clock; all flops rise-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to send; sampled on accept.
- in_valid  input  1  producer offers `in_data`.
- in_ready  output  1  block can accept; transfer occurs on an edge with in_valid && in_ready.
- ack_nsyn  input  1  asynchronous acknowledge from the receiving domain.
- req  output  1  registered request level to the receiving domain.
- out_data  output  WIDTH  registered data to the receiving domain.
- ack_syn  output  1  last stage of the ack synchronizer, for observation.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a handshake fully completes.

Behaviour:
- Reset (async assert, takes effect immediately):
  - req=0, out_data=0, done=0, state=IDLE.
  - All SYNC_STAGES sync flops = 0, so ack_syn=0.
- Synchronizer:
  - Stage 1 samples ack_nsyn each edge; each later stage samples the previous one.
  - ack_syn = last stage.
  - No logic other than the chain reads stage 1.
- in_ready = (state==IDLE) && !ack_syn. This is combinational from registers only; it never depends on in_valid.
- FSM states are IDLE, REQ and WAIT_LOW.
  - IDLE: on an edge with in_valid && in_ready:
    - out_data <= in_data, req <= 1, go to REQ.
    - req and the new out_data appear together after that edge, so out_data is valid no later than req rises.
  - REQ: req held 1 and out_data held constant. When ack_syn==1 on an edge: req <= 0, go to WAIT_LOW.
  - WAIT_LOW: req=0 and out_data still held. When ack_syn==0 on an edge: done <= 1 for exactly one cycle, go to IDLE.
- Latency and throughput:
  - Let edge k be the first edge sampling ack_nsyn=1. ack_syn is high after edge k+SYNC_STAGES-1, and req falls at edge k+SYNC_STAGES.
  - ack fall to done follows the same rule: done is asserted after edge k'+SYNC_STAGES.
  - The next accept is possible on the edge after done, since in_ready rises with the return to IDLE.
- out_data changes only on an accepted transfer. It is never modified in REQ or WAIT_LOW.
- Stale/glitched ack:
  - If ack_syn is high in IDLE, in_ready=0 and no accept occurs until it clears.
  - In REQ, ack must be seen high on a sampled edge; a pulse shorter than one clk period may be missed, and req then stays high (no timeout).
- Reset mid-operation: req drops to 0 asynchronously, the FSM returns to IDLE, and the in-flight word is discarded. done is not pulsed.
- in_valid asserted in REQ/WAIT_LOW is ignored (in_ready=0); the producer must hold it.

Test Plan:
- Reset: rst=1 with ack_nsyn=1 -> req=0, out_data=0, ack_syn=0, busy=0, done=0. After release, in_ready stays 0 until ack_nsyn=0 has propagated 3 edges.
- Single transfer, WIDTH=8, SYNC_STAGES=3: in_data=8'hA5 with in_valid=1 for one edge -> req=1 and out_data=8'hA5 after that edge. Raise ack_nsyn -> req falls exactly 3 edges after the first sampling edge. Drop ack_nsyn -> done=1 for one cycle 3 edges later, then in_ready=1.
- Data hold: toggle in_data randomly (8'h00..8'hFF) while busy=1 -> out_data remains 8'hA5 throughout REQ and WAIT_LOW.
- Back-to-back: producer holds in_valid=1 for 8'h01, 8'h02, 8'h03 with an ideal responder -> exactly three req pulses carrying 01, 02, 03 in order, three done pulses, no duplicated or lost word.
- Stale ack: ack_nsyn=1 while IDLE with in_valid=1, in_data=8'h3C -> no accept (req stays 0). Drop ack_nsyn -> accept occurs on the first edge with ack_syn=0 and in_ready=1.
- Reset mid-handshake: assert rst while in REQ -> req=0 immediately, before the next clk edge, and no done. After release, a new transfer of 8'h77 completes normally.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
//
// Sending end of a 4-phase req/ack clock-domain crossing. A word is accepted
// from a local valid/ready producer. It is then presented on out_data together
// with a level req toward a foreign clock domain. The receiver's asynchronous
// ack is brought into this domain through a SYNC_STAGES-deep flop chain.
// The FSM then completes the four phases:
//   req up -> ack up -> req down -> ack down -> done.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    word to send, sampled on accept
//   in_valid   producer offers in_data
//   in_ready   block can accept (IDLE and synchronized ack low)
//   ack_nsyn   asynchronous acknowledge from the receiving domain
//   req        registered request level to the receiving domain
//   out_data   registered data to the receiving domain
//   ack_syn    last stage of the ack synchronizer
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse when a handshake fully completes
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 3   // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ack_nsyn,
  output logic             req,
  output logic [WIDTH-1:0] out_data,
  output logic             ack_syn,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  // Synchronizer chain. Stage 0 is the only flop that sees the asynchronous
  // ack. Nothing except the next stage reads it, so metastability has
  // SYNC_STAGES-1 cycles to resolve before the FSM sees the value.
  assign sync_d[0] = ack_nsyn;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign ack_syn = sync_q[SYNC_STAGES-1];

  // A leftover high ack from a previous or aborted handshake blocks new
  // accepts. Otherwise the receiver could see a req rise while its ack is
  // still up.
  assign in_ready = (state_q == ST_IDLE) && !ack_syn;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          // Data and req update on the same edge. Data is therefore stable
          // no later than req rises.
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_syn) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_syn) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

  assign req      = req_q;
  assign out_data = data_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
